// File: rtl/washer_pkg.sv
`default_nettype none
// ============================================================================
// washer_pkg : phase encodings and default timing for the washer plant model
// Revision   : 1.0
// ============================================================================
package washer_pkg;

  localparam logic [2:0] PH_IDLE     = 3'd0;
  localparam logic [2:0] PH_FILL     = 3'd1;
  localparam logic [2:0] PH_DOSE     = 3'd2;
  localparam logic [2:0] PH_WASH     = 3'd3;
  localparam logic [2:0] PH_DRAIN    = 3'd4;
  localparam logic [2:0] PH_SPIN     = 3'd5;
  localparam logic [2:0] PH_COMPLETE = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE     = PH_IDLE,
    ST_FILL     = PH_FILL,
    ST_DOSE     = PH_DOSE,
    ST_WASH     = PH_WASH,
    ST_DRAIN    = PH_DRAIN,
    ST_SPIN     = PH_SPIN,
    ST_COMPLETE = PH_COMPLETE
  } phase_t;

  localparam int DEF_PRESCALE    = 4;
  localparam int DEF_LEVEL_W     = 8;
  localparam int DEF_LEVEL_FULL  = 200;
  localparam int DEF_DOSE_TICKS  = 5;
  localparam int DEF_CYCLE_TICKS = 50;
  localparam int DEF_SPIN_TICKS  = 30;
  localparam int DEF_TIMER_W     = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/washer_prescaler.sv
`default_nettype none
// ============================================================================
// washer_prescaler : free-running 0..PRESCALE-1 counter, tick on last count
// Revision         : 1.0
// ============================================================================
module washer_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int c_cnt_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(PRESCALE - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/washer_plant_model.sv
`default_nettype none
// ============================================================================
// washer_plant_model : drum level, dispenser and phase timers driven by the
//                      washer controller's actuator commands
// Revision           : 1.0
// ============================================================================
module washer_plant_model
  import washer_pkg::*;
#(
  parameter int PRESCALE    = DEF_PRESCALE,
  parameter int LEVEL_W     = DEF_LEVEL_W,
  parameter int LEVEL_FULL  = DEF_LEVEL_FULL,
  parameter int DOSE_TICKS  = DEF_DOSE_TICKS,
  parameter int CYCLE_TICKS = DEF_CYCLE_TICKS,
  parameter int SPIN_TICKS  = DEF_SPIN_TICKS,
  parameter int TIMER_W     = DEF_TIMER_W
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Motor_on,
  input  logic               Fill_valve_on,
  input  logic               Drained_valve_on,
  input  logic               Door_Lock,
  input  logic               Done,
  output logic               Filled,
  output logic               Drained,
  output logic               Detergent_Added,
  output logic               Cycle_Timeout,
  output logic               Spin_Timeout,
  output logic [LEVEL_W-1:0] Water_Level,
  output logic [2:0]         Phase,
  output logic               Fault
);

  localparam int c_max_ticks = max3(DOSE_TICKS, CYCLE_TICKS, SPIN_TICKS);
  localparam logic [LEVEL_W-1:0] c_full  = LEVEL_W'(LEVEL_FULL);
  localparam logic [TIMER_W-1:0] c_dose  = TIMER_W'(DOSE_TICKS);
  localparam logic [TIMER_W-1:0] c_cycle = TIMER_W'(CYCLE_TICKS);
  localparam logic [TIMER_W-1:0] c_spin  = TIMER_W'(SPIN_TICKS);

  if ($clog2(c_max_ticks + 1) > TIMER_W) begin : g_timer_w_check
    $error("washer_plant_model: TIMER_W too narrow for the largest *_TICKS value");
  end

  logic               w_tick;
  phase_t             r_phase,   w_phase_nxt;
  logic [TIMER_W-1:0] r_timer,   w_timer_nxt;
  logic [TIMER_W-1:0] w_timer_inc;
  logic [LEVEL_W-1:0] r_level,   w_level_nxt;
  logic               r_det,     w_det_nxt;
  logic               r_cyc,     w_cyc_nxt;
  logic               r_spin,    w_spin_nxt;
  logic               r_fault,   w_fault_nxt;
  logic               w_abort;

  washer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (Clock),
    .rst_n  (Reset_n),
    .o_tick (w_tick)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_phase <= ST_IDLE;
      r_timer <= '0;
      r_level <= '0;
      r_det   <= 1'b0;
      r_cyc   <= 1'b0;
      r_spin  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      r_timer <= w_timer_nxt;
      r_level <= w_level_nxt;
      r_det   <= w_det_nxt;
      r_cyc   <= w_cyc_nxt;
      r_spin  <= w_spin_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  assign w_timer_inc = r_timer + 1'b1;
  assign w_fault_nxt = (Fill_valve_on & Drained_valve_on) | (Motor_on & ~Door_Lock);
  assign w_abort     = ~Door_Lock && (r_phase inside {ST_FILL, ST_DOSE, ST_WASH, ST_DRAIN, ST_SPIN});

  // Water moves in every phase; simultaneous fill and drain cancel out.
  always_comb begin
    w_level_nxt = r_level;
    if (w_tick) begin
      if (Fill_valve_on && !Drained_valve_on && (r_level < c_full)) begin
        w_level_nxt = r_level + 1'b1;
      end else if (Drained_valve_on && !Fill_valve_on && (r_level != '0)) begin
        w_level_nxt = r_level - 1'b1;
      end
    end
  end

  always_comb begin
    w_phase_nxt = r_phase;
    w_timer_nxt = r_timer;
    w_det_nxt   = r_det;
    w_cyc_nxt   = r_cyc;
    w_spin_nxt  = r_spin;
    if (w_abort) begin
      w_phase_nxt = ST_IDLE;
      w_timer_nxt = '0;
      w_det_nxt   = 1'b0;
      w_cyc_nxt   = 1'b0;
      w_spin_nxt  = 1'b0;
    end else begin
      case (r_phase)
        ST_IDLE: begin
          if (Fill_valve_on && Door_Lock) begin
            w_phase_nxt = ST_FILL;
            w_timer_nxt = '0;
          end
        end
        ST_FILL: begin
          if (r_level == c_full) begin
            w_phase_nxt = ST_DOSE;
            w_timer_nxt = '0;
          end
        end
        ST_DOSE: begin
          // Dispenser stops timing once detergent is in.
          if (w_tick && !r_det) begin
            if (w_timer_inc == c_dose) begin
              w_det_nxt   = 1'b1;
              w_timer_nxt = '0;
            end else begin
              w_timer_nxt = w_timer_inc;
            end
          end
          if (r_det && Motor_on) begin
            w_phase_nxt = ST_WASH;
            w_timer_nxt = '0;
          end
        end
        ST_WASH: begin
          if (w_tick && Motor_on && !Drained_valve_on && (r_timer != c_cycle)) begin
            w_timer_nxt = w_timer_inc;
            if (w_timer_inc == c_cycle) begin
              w_cyc_nxt = 1'b1;
            end
          end
          if (r_cyc && Drained_valve_on) begin
            w_phase_nxt = ST_DRAIN;
            w_timer_nxt = '0;
          end
        end
        ST_DRAIN: begin
          if ((r_level == '0) && Motor_on) begin
            w_phase_nxt = ST_SPIN;
            w_timer_nxt = '0;
          end
        end
        ST_SPIN: begin
          if (w_tick && Motor_on && (r_timer != c_spin)) begin
            w_timer_nxt = w_timer_inc;
            if (w_timer_inc == c_spin) begin
              w_spin_nxt  = 1'b1;
              w_phase_nxt = ST_COMPLETE;
            end
          end
        end
        ST_COMPLETE: begin
          if (Done) begin
            w_phase_nxt = ST_IDLE;
            w_det_nxt   = 1'b0;
            w_cyc_nxt   = 1'b0;
            w_spin_nxt  = 1'b0;
          end
        end
        default: begin
          w_phase_nxt = ST_IDLE;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

  assign Filled          = (r_level == c_full);
  assign Drained         = (r_level == '0);
  assign Detergent_Added = r_det;
  assign Cycle_Timeout   = r_cyc;
  assign Spin_Timeout    = r_spin;
  assign Water_Level     = r_level;
  assign Phase           = r_phase;
  assign Fault           = r_fault;

endmodule
`default_nettype wire

// File: doc/washer_plant_model.md
Name: washer_plant_model

Overview:
- Synthesizable drum/sensor/timer model, the other end of the automatic washing machine controller's actuator interface.
- Consumes the controller's actuator outputs (Motor_on, Fill_valve_on, Drained_valve_on, Door_Lock, Done).
- Produces the sensor and timer inputs the controller expects (Filled, Drained, Detergent_Added, Cycle_Timeout, Spin_Timeout).
- Used for closed-loop controller verification and as the sequencing/timer front end on the board.

Parameters:
PRESCALE, 4, clocks per plant tick (>=1)
LEVEL_W, 8, water-level counter width
LEVEL_FULL, 200, level at which drum is full (<2^LEVEL_W)
DOSE_TICKS, 5, ticks from full to detergent dispensed
CYCLE_TICKS, 50, wash-agitation ticks before Cycle_Timeout
SPIN_TICKS, 30, spin ticks before Spin_Timeout
TIMER_W, 16, phase timer width

Ports:
Clock  input  1  system clock, rising edge
Reset_n  input  1  asynchronous, active-low reset
Motor_on  input  1  drum motor command
Fill_valve_on  input  1  inlet valve command
Drained_valve_on  input  1  drain valve command
Door_Lock  input  1  door lock command
Done  input  1  controller cycle-complete
Filled  output  1  level == LEVEL_FULL
Drained  output  1  level == 0
Detergent_Added  output  1  dispenser complete, sticky per run
Cycle_Timeout  output  1  wash time elapsed, sticky per run
Spin_Timeout  output  1  spin time elapsed, sticky per run
Water_Level  output  LEVEL_W  current level
Phase  output  3  IDLE=0 FILL=1 DOSE=2 WASH=3 DRAIN=4 SPIN=5 COMPLETE=6
Fault  output  1  illegal actuator combination

Behaviour:
- One clock domain; one always block holds async reset on negedge Reset_n.
- Reset values: level=0, Phase=IDLE, all timers=0, all sticky flags=0, Fault=0, prescaler=0. Filled=0 and Drained=1 (empty drum).
- Prescaler: counts 0..PRESCALE-1 free-running; tick=1 in the cycle where count==PRESCALE-1. With PRESCALE=1, tick is always 1.
- Level (on tick only):
  - Fill_valve_on & !Drained_valve_on: +1, saturating at LEVEL_FULL.
  - Drained_valve_on & !Fill_valve_on: -1, saturating at 0.
  - Both on, or both off: hold.
- Level updates in every Phase, IDLE included.
- Filled and Drained decode combinationally from the level register (0-cycle after the level edge).
- Fault is registered. It is 1 the cycle after either condition is true:
  - (Fill_valve_on & Drained_valve_on), or
  - (Motor_on & !Door_Lock).
- Fault is not sticky and has no effect on the FSM.
- Phase FSM (evaluated every clock; timers advance on tick only):
  - IDLE -> FILL when Fill_valve_on & Door_Lock.
  - FILL -> DOSE when level==LEVEL_FULL; timer cleared.
  - DOSE: timer++ per tick. When timer reaches DOSE_TICKS, Detergent_Added<=1 and timer cleared. Go to WASH when Detergent_Added & Motor_on.
  - WASH: timer++ per tick while Motor_on & !Drained_valve_on. When timer reaches CYCLE_TICKS, Cycle_Timeout<=1 and timer holds. Go to DRAIN when Cycle_Timeout & Drained_valve_on; timer cleared.
  - DRAIN -> SPIN when level==0 & Motor_on; timer cleared.
  - SPIN: timer++ per tick while Motor_on. When timer reaches SPIN_TICKS, Spin_Timeout<=1. Go to COMPLETE on the same edge.
  - COMPLETE -> IDLE when Done==1. The transition clears Detergent_Added, Cycle_Timeout and Spin_Timeout.
- Flags and timing:
  - Flags rise on the clock edge of the tick on which the timer reaches its terminal count (latency 1 clock from that tick).
  - Flags are never cleared except by Done in COMPLETE, door abort, or reset.
- Door abort: Door_Lock==0 in FILL, DOSE, WASH, DRAIN or SPIN forces IDLE next clock. It clears timer and flags; level is retained.
- Motor_on dropping in WASH or SPIN freezes the timer (no clear).
- Timer width: compare with ==. Timers saturate at their terminal count and never wrap. TIMER_W must exceed log2 of the largest *_TICKS value; this is checked by an elaboration-time assertion.
- Reset mid-run: immediate return to reset values, including level=0.

Decomposition:
- Shared package `washer_pkg`: Phase encodings as localparams (PH_IDLE..PH_COMPLETE) and the default tick constants. The controller and bench also use these.
- Sub-module `washer_prescaler`: PRESCALE counter producing tick. Everything else stays in washer_plant_model.

Test Plan:
(bench params for all scenarios: PRESCALE=1, LEVEL_FULL=4, DOSE_TICKS=2, CYCLE_TICKS=3, SPIN_TICKS=2)
- Reset: hold Reset_n=0, drive random actuator inputs -> Phase=0, Water_Level=0, Drained=1, Filled=0, all flags 0, Fault=0.
- Fill: Door_Lock=1, Fill_valve_on=1 -> Phase=1 next clock, level 1,2,3,4 on successive clocks, Filled=1 at level 4, Phase=2. Detergent_Added=1 two clocks later.
- Full run: Motor_on=1 in DOSE -> WASH. Cycle_Timeout=1 after 3 clocks. Drained_valve_on=1 -> DRAIN, level 4->0 in 4 clocks. Motor_on=1 -> SPIN, Spin_Timeout=1 after 2 clocks and Phase=6. Done=1 -> Phase=0 with all flags 0.
- Door abort: drop Door_Lock during WASH at timer=2 -> Phase=0 next clock, Cycle_Timeout stays 0, Water_Level stays 4.
- Fault/saturation: Fill_valve_on=Drained_valve_on=1 -> Fault=1 next clock, level held. Fill at level 4 -> stays 4. Drain at 0 -> stays 0. Motor_on=1 with Door_Lock=0 -> Fault=1.
- Prescale: PRESCALE=4 -> level increments every 4th clock, and the first increment lands on clock 4 after reset release.
